// File: rtl/apb_wait_slave.sv
// APB completer: DEPTH-byte register file with WAIT_CYCLES wait states and PSLVERR on out-of-range access.
// Optional lock register at the all-ones address, enabled by defining APB_SLV_LOCK_EN.
module apb_wait_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              pclk_i,
  input  logic              preset_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [DATA_W-1:0] pwdata_i,
  output logic [DATA_W-1:0] prdata_o,
  output logic              pready_o,
  output logic              pslverr_o
);

  // state  | meaning
  // IDLE   | no transfer, waiting for a setup phase
  // ACCESS | wait counter running; PREADY is high when it has reached zero
  // DONE   | one cycle after completion; a new setup may start here
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;

  localparam int CNT_W = 4;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                setup;
  logic                complete;
  logic                in_range_d, in_range_q;
  logic                lock_hit_d, lock_hit_q;
  logic                lock_now;
  logic                err_d, err_q;
  logic                mem_we;
  logic [IDX_W-1:0]    idx_d, idx_q;

  assign setup      = psel_i && !penable_i;
  assign complete   = (state_q == ST_ACCESS) && (cnt_q == '0);

  assign in_range_d = int'(addr_d) < DEPTH;
  assign in_range_q = int'(addr_q) < DEPTH;
  assign idx_d      = addr_d[IDX_W-1:0];
  assign idx_q      = addr_q[IDX_W-1:0];

`ifdef APB_SLV_LOCK_EN
  localparam logic [ADDR_W-1:0] LOCK_ADDR = '1;
  logic lock_q;

  assign lock_hit_d = (addr_d == LOCK_ADDR);
  assign lock_hit_q = (addr_q == LOCK_ADDR);
  assign lock_now   = lock_q;

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      lock_q <= 1'b0;
    end else if (complete && write_q && lock_hit_q) begin
      lock_q <= wdata_q[0];
    end
  end
`else
  assign lock_hit_d = 1'b0;
  assign lock_hit_q = 1'b0;
  assign lock_now   = 1'b0;
`endif

  // The lock register itself is never in error; locked writes to the array are.
  assign err_d  = !lock_hit_d && (!in_range_d || (write_d && lock_now));
  assign err_q  = !lock_hit_q && (!in_range_q || (write_q && lock_now));
  assign mem_we = complete && write_q && !err_q && !lock_hit_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (setup) begin
          state_d = ST_ACCESS;
          cnt_d   = WAIT_LD;
          addr_d  = paddr_i;
          write_d = pwrite_i;
          wdata_d = pwdata_i;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else if (!psel_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Response is registered one cycle ahead so PREADY lands exactly in T1+WAIT_CYCLES.
  always_comb begin
    pready_d  = (state_d == ST_ACCESS) && (cnt_d == '0);
    pslverr_d = pready_d && err_d;
    prdata_d  = '0;
    if (pready_d && !write_d && !err_d) begin
      if (lock_hit_d) begin
        prdata_d = DATA_W'(lock_now);
      end else begin
        prdata_d = mem_q[idx_d];
      end
    end
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign prdata_o  = prdata_q;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;

endmodule

// File: doc/apb_wait_slave.md
Name: apb_wait_slave

Overview:
- APB completer that sits directly downstream of the APB master bridge, on one PSELx output.
- Provides a DEPTH-byte register file with a programmable number of wait states, PREADY-driven completion and PSLVERR for out-of-range accesses.
- Pin-compatible with the existing slave slots: PRDATA/PREADY feed the top-level PADDR[8] mux.

Parameters:
- ADDR_W, 8, PADDR width (the bridge passes PADDR[7:0]).
- DATA_W, 8, PWDATA/PRDATA width.
- DEPTH, 64, number of implemented bytes at addresses 0..DEPTH-1; legal range 1..255.
- WAIT_CYCLES, 2, wait states inserted before PREADY; legal range 0..15.

Ports:
- PCLK  input  1  bus clock; all logic on the rising edge.
- PRESET  input  1  reset; synchronous, active-high.
- PSEL  input  1  slave select from the bridge.
- PENABLE  input  1  access-phase strobe.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_W  byte address.
- PWDATA  input  DATA_W  write data.
- PRDATA  output  DATA_W  read data; valid only while PREADY=1.
- PREADY  output  1  transfer completion.
- PSLVERR  output  1  error flag; valid only while PREADY=1.

Behaviour:
- Clock and reset: one clock, PCLK. Reset is synchronous, active-high, on port PRESET.
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, state=IDLE, wait counter=0, all memory bytes=0, lock=0.
- Outputs: PRDATA, PREADY and PSLVERR are registered; no combinational input-to-output path.
- IDLE:
  - PSEL=1 and PENABLE=0 (setup phase, cycle T0) latches PADDR, PWRITE and PWDATA, loads the counter with WAIT_CYCLES, and moves to ACCESS.
  - PSEL=1 and PENABLE=1 without a prior setup is ignored: stay in IDLE, PREADY stays 0.
- ACCESS (PSEL=1 and PENABLE=1 from cycle T1):
  - The counter decrements each cycle.
  - PREADY=1 in exactly one cycle, T1+WAIT_CYCLES. WAIT_CYCLES=0 gives a zero-wait transfer with PREADY high in T1.
  - The state then moves to DONE.
- Completion cycle:
  - Read: PRDATA = mem[latched addr].
  - Write: mem[latched addr] <= latched PWDATA at the rising edge that ends the PREADY cycle.
  - Bus values that change during access are ignored; only the latched values are used.
- Error:
  - Latched address >= DEPTH gives PSLVERR=1 alongside PREADY=1, PRDATA=0, and no memory change.
  - PSLVERR is otherwise 0.
- DONE (one cycle, PREADY back to 0, PRDATA back to 0):
  - PSEL=1 and PENABLE=0 is a back-to-back setup, handled exactly as in IDLE.
  - Anything else returns to IDLE.
- Abort: PSEL=0 while in ACCESS before PREADY returns to IDLE next cycle, with no write and all outputs 0.
- Reset mid-transfer: PRESET overrides all states. An in-flight write is not committed.
- Simultaneous events: PRESET wins over any bus activity in the same cycle.
- Memory: DEPTH x DATA_W flop array, synchronous write, registered read.

Optional Feature:
Macro: APB_SLV_LOCK_EN
- Defined:
  - Address 8'hFF is a lock register, always accessible and never in error.
  - Write sets lock = PWDATA[0]; read returns {7'b0, lock}.
  - While lock=1, writes to 0..DEPTH-1 complete with PSLVERR=1 and no memory change; reads are unaffected.
  - lock resets to 0.
- Not defined: no lock register. Address 8'hFF is out of range like any other address >= DEPTH, giving PSLVERR=1.

Test Plan:
- Reset then read: PRESET high 2 cycles; WAIT_CYCLES=2, read 0x05 -> PREADY high only in T3, PRDATA=0x00, PSLVERR=0.
- Write then read back: write 0xA5 to 0x10, then read 0x10 -> read completes with PRDATA=0xA5. With WAIT_CYCLES=0, PREADY is high in T1 of each transfer.
- Out of range: DEPTH=64, write 0x3C to 0x40, then read 0x40 -> PSLVERR=1 with PREADY on both transfers, PRDATA=0. A subsequent read of 0x00 returns its previous value.
- Abort and reset:
  - Write 0x77 to 0x20, drop PSEL in T1 (WAIT_CYCLES=3) -> no PREADY, mem[0x20] unchanged.
  - Repeat, asserting PRESET in T2 -> all outputs 0 next cycle, mem cleared.
- Back-to-back: write 0x11 to 0x01 immediately followed by setup of a read of 0x01 in the DONE cycle -> second PREADY WAIT_CYCLES+2 cycles after the first, PRDATA=0x11.
- APB_SLV_LOCK_EN:
  - Write 0x01 to 0xFF, then write 0x99 to 0x02 -> PSLVERR=1, mem[0x02] unchanged.
  - Read 0xFF -> 0x01.
  - Write 0x00 to 0xFF, retry the write of 0x99 to 0x02 -> PSLVERR=0, and a read of 0x02 returns 0x99.
